// File: rtl/tick_divider_pkg.sv
// Shared types and default timebase constants for tick_divider.
// Defaults give a 1 s / 1 min / 1 h cascade.
package tick_divider_pkg;

  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned PERIOD_RST_DEF = 10;
  localparam int unsigned NUM_CH_DEF     = 2;
  localparam int unsigned RATIO_W_DEF    = 8;

  localparam logic [15:0] RATIOS_DEF = {8'd60, 8'd60};

  // Base-counter action for one clock edge, in priority order.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_COUNT,
    OP_LOAD,
    OP_CLEAR
  } base_op_e;

endpackage

// File: rtl/tick_stage.sv
// One cascaded divider stage: emits out_tick on every RATIO-th in_tick.
// A pulse that arrives while en is low is remembered, not dropped.
module tick_stage #(
  parameter int unsigned          RATIO_W = 8,
  parameter logic [RATIO_W-1:0]   RATIO   = 8'd60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic in_tick,
  output logic out_tick
);

  localparam logic [RATIO_W-1:0] ONE  = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] LAST =
    (RATIO == '0) ? '0 : RATIO - ONE;

  logic [RATIO_W-1:0] cnt;
  logic               pend;
  logic               fire;

  assign fire = in_tick | pend;

  // Stage counter with wrap, gap-preserving pending bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      pend     <= 1'b0;
      out_tick <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      pend     <= 1'b0;
      out_tick <= 1'b0;
    end else if (!en) begin
      pend     <= pend | in_tick;
      out_tick <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (fire && cnt >= LAST) begin
        cnt      <= '0;
        out_tick <= 1'b1;
      end else if (fire) begin
        cnt      <= cnt + ONE;
        out_tick <= 1'b0;
      end else begin
        out_tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_divider.sv
// Programmable base tick plus NUM_CH cascaded divider stages.
// Priority: reset > clear > period load > enable.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned PERIOD_RST = PERIOD_RST_DEF,
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned RATIO_W    = RATIO_W_DEF,
  parameter logic [NUM_CH*RATIO_W-1:0] RATIOS = RATIOS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              period_load,
  input  logic [CNT_W-1:0]  period_in,
  output logic              tick_base,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [CNT_W-1:0]  period_q,
  output logic [CNT_W-1:0]  base_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PERIOD_INIT =
    (PERIOD_RST == 0) ? ONE : CNT_W'(PERIOD_RST);

  base_op_e         op;
  logic [CNT_W-1:0] period_nxt;
  logic             term;
  logic [NUM_CH-1:0] stage_in;

  assign period_nxt = (period_in == '0) ? ONE : period_in;
  assign term       = base_cnt >= (period_q - ONE);

  // Decode this edge's base-counter action.
  always_comb begin
    op = OP_HOLD;
    unique case (1'b1)
      clr:                         op = OP_CLEAR;
      !clr && period_load:         op = OP_LOAD;
      !clr && !period_load && en:  op = OP_COUNT;
      default:                     op = OP_HOLD;
    endcase
  end

  // Period register; a load also lands during a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_q <= PERIOD_INIT;
    end else if (period_load) begin
      period_q <= period_nxt;
    end
  end

  // Base counter and its one-cycle terminal pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_cnt  <= '0;
      tick_base <= 1'b0;
    end else begin
      unique case (op)
        OP_CLEAR, OP_LOAD: begin
          base_cnt  <= '0;
          tick_base <= 1'b0;
        end
        OP_COUNT: begin
          if (term) begin
            base_cnt  <= '0;
            tick_base <= 1'b1;
          end else begin
            base_cnt  <= base_cnt + ONE;
            tick_base <= 1'b0;
          end
        end
        default: begin
          tick_base <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_in[k] = tick_base;
    end else begin : g_next
      assign stage_in[k] = ch_tick[k-1];
    end

    tick_stage #(
      .RATIO_W (RATIO_W),
      .RATIO   (RATIOS[k*RATIO_W +: RATIO_W])
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .in_tick  (stage_in[k]),
      .out_tick (ch_tick[k])
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider, period 10, stage ratios 3 and 2.
// Expected outputs are queued per step and popped after the edge.
module tb_tick_divider;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic        period_load;
  logic [31:0] period_in;
  logic        tick_base;
  logic [1:0]  ch_tick;
  logic [31:0] period_q;
  logic [31:0] base_cnt;

  typedef struct {
    string       tag;
    logic        tb;
    logic [1:0]  ch;
    logic [31:0] pq;
    logic [31:0] cnt;
  } exp_t;

  exp_t  sb[$];
  string phase;
  int    n_vec;
  int    n_bad;

  tick_divider #(
    .CNT_W      (32),
    .PERIOD_RST (10),
    .NUM_CH     (2),
    .RATIO_W    (8),
    .RATIOS     ({8'd2, 8'd3})
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .period_load (period_load),
    .period_in   (period_in),
    .tick_base   (tick_base),
    .ch_tick     (ch_tick),
    .period_q    (period_q),
    .base_cnt    (base_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic e,
                      input logic c, input logic ld,
                      input logic [31:0] pin,
                      input logic etb, input logic [1:0] ech,
                      input logic [31:0] epq, input logic [31:0] ecnt);
    exp_t x;
    @(negedge clk);
    rst_n       = rn;
    en          = e;
    clr         = c;
    period_load = ld;
    period_in   = pin;
    x.tag = phase;
    x.tb  = etb;
    x.ch  = ech;
    x.pq  = epq;
    x.cnt = ecnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    cmp({x.tag, ".tick_base"}, 32'(tick_base), 32'(x.tb));
    cmp({x.tag, ".ch_tick"}, 32'(ch_tick), 32'(x.ch));
    cmp({x.tag, ".period_q"}, period_q, x.pq);
    cmp({x.tag, ".base_cnt"}, base_cnt, x.cnt);
  endtask

  // Enabled edges counted from reset with period 10.
  task automatic run(input int lo, input int hi);
    for (int e = lo; e <= hi; e++) begin
      step(1, 1, 0, 0, 0,
           (e % 10) == 0,
           {e == 62, (e == 31) || (e == 61)},
           32'd10, 32'(e % 10));
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 0;
    en = 0;
    clr = 0;
    period_load = 0;
    period_in = 0;

    phase = "reset";
    step(0, 0, 0, 0, 0, 0, 2'b00, 10, 0);

    phase = "cascade";
    run(1, 67);

    phase = "load4";
    step(1, 1, 0, 1, 4, 0, 2'b00, 4, 0);
    for (int j = 1; j <= 12; j++)
      step(1, 1, 0, 0, 0, (j % 4) == 0, 2'b00, 4, 32'(j % 4));

    phase = "load0";
    step(1, 1, 0, 1, 0, 0, 2'b01, 1, 0);
    for (int k = 1; k <= 6; k++)
      step(1, 1, 0, 0, 0, 1, {k == 5, k == 4}, 1, 0);

    phase = "setup";
    step(1, 1, 1, 1, 10, 0, 2'b00, 10, 0);

    phase = "en_gap";
    for (int j = 1; j <= 6; j++)
      step(1, 1, 0, 0, 0, 0, 2'b00, 10, 32'(j));
    for (int j = 0; j < 5; j++)
      step(1, 0, 0, 0, 0, 0, 2'b00, 10, 6);
    for (int j = 7; j <= 10; j++)
      step(1, 1, 0, 0, 0, j == 10, 2'b00, 10, 32'(j % 10));
    step(1, 1, 0, 0, 0, 0, 2'b00, 10, 1);

    phase = "clr_load";
    for (int j = 2; j <= 9; j++)
      step(1, 1, 0, 0, 0, 0, 2'b00, 10, 32'(j));
    step(1, 1, 1, 1, 5, 0, 2'b00, 5, 0);
    for (int j = 1; j <= 5; j++)
      step(1, 1, 0, 0, 0, j == 5, 2'b00, 5, 32'(j % 5));
    step(1, 1, 0, 1, 10, 0, 2'b00, 10, 0);
    for (int j = 1; j <= 10; j++)
      step(1, 1, 0, 0, 0, j == 10, 2'b00, 10, 32'(j % 10));
    for (int j = 1; j <= 8; j++)
      step(1, 1, 0, 0, 0, 0, 2'b00, 10, 32'(j));

    phase = "midreset";
    step(0, 1, 0, 0, 0, 0, 2'b00, 10, 0);
    run(1, 40);
    for (int j = 0; j < 3; j++)
      step(1, 0, 0, 0, 0, 0, 2'b00, 10, 0);
    run(41, 62);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
